// File: rtl/wembley_pkg.sv
// Shared types, framing constants and parity helper for the wembley serial receiver.
package wembley_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StPar,
        StStop
    } state_e;

    localparam int unsigned W_DEF      = 4;
    localparam int unsigned FRAME_BITS = 3 * W_DEF + 3;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    function automatic int unsigned frame_bits(input int unsigned w);
        return 3 * w + 3;
    endfunction

    // XOR of the data word; a correct even-parity bit equals this value.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/wembley_rx_buf.sv
// One-entry valid/ready output register with overrun detection and frame counter.
module wembley_rx_buf
    import wembley_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    input  logic [W-1:0]     c_in,
    input  logic             out_ready,
    output logic [W-1:0]     A_e,
    output logic [W-1:0]     B_e,
    output logic [W-1:0]     C_e,
    output logic             out_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt
);

    logic [W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             accept;

    // A full buffer can still take a new frame if the old one drains this cycle.
    assign accept = load && (!valid_q || out_ready);

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;
        if (accept) begin
            a_d         = a_in;
            b_d         = b_in;
            c_d         = c_in;
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 1'b1;
        end else begin
            if (load) begin
                overrun_d = 1'b1;
            end
            if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign A_e       = a_q;
    assign B_e       = b_q;
    assign C_e       = c_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: rtl/wembley_rx.sv
// Wembley serial receiver: start detect, A/B/C deserializer, parity/stop checks, error stats.
module wembley_rx
    import wembley_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Yin,
    output logic [W-1:0]     A_e,
    output logic [W-1:0]     B_e,
    output logic [W-1:0]     C_e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned FrameBits = frame_bits(W);
    localparam int unsigned DataBits  = FrameBits - 3;
    localparam int unsigned BitCntW   = $clog2(DataBits);

    state_e              state_q, state_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic                par_q, par_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                good_frame;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        good_frame   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Yin == START_BIT) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                shift_d   = {shift_q[DataBits-2:0], Yin};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BitCntW'(DataBits - 1)) begin
                    state_d = StPar;
                end
            end
            StPar: begin
                par_d   = Yin;
                state_d = StStop;
            end
            StStop: begin
                // Back to idle unconditionally: the stop bit never doubles as a start bit.
                state_d = StIdle;
                if (Yin != STOP_BIT) begin
                    frame_err_d = 1'b1;
                end else if (even_parity(32'(shift_q)) != par_q) begin
                    parity_err_d = 1'b1;
                end else begin
                    good_frame = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        err_cnt_d = err_cnt_q;
        if ((parity_err_d || frame_err_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    wembley_rx_buf #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (good_frame),
        .a_in      (shift_q[3*W-1:2*W]),
        .b_in      (shift_q[2*W-1:W]),
        .c_in      (shift_q[W-1:0]),
        .out_ready (out_ready),
        .A_e       (A_e),
        .B_e       (B_e),
        .C_e       (C_e),
        .out_valid (out_valid),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_wembley_rx.sv
// Directed self-checking bench for wembley_rx at default W=4, CNT_W=8.
module tb_wembley_rx;
    import wembley_pkg::*;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             Yin;
    logic             out_ready;
    logic [W-1:0]     A_e, B_e, C_e;
    logic             out_valid, parity_err, frame_err, overrun;
    logic [CNT_W-1:0] frame_cnt, err_cnt;

    int total = 0;
    int bad   = 0;

    wembley_rx #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Yin        (Yin),
        .A_e        (A_e),
        .B_e        (B_e),
        .C_e        (C_e),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Drive one serial bit, then land 1 time unit after the edge that samples it.
    task automatic send_bit(input logic b);
        Yin = b;
        @(posedge clk);
        #1;
    endtask

    // Start bit, A/B/C MSB first, parity (optionally corrupted): cycles 0..3W+1.
    task automatic send_body(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic flip);
        logic [3*W-1:0] word;
        word = {a, b, c};
        send_bit(1'b1);
        for (int i = 3 * W - 1; i >= 0; i--) send_bit(word[i]);
        send_bit((^word) ^ flip);
    endtask

    task automatic send_stop(input logic s);
        send_bit(s);
        Yin = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        Yin       = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_a", A_e, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_ecnt", err_cnt, 0);
        chk("rst_ovr", overrun, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Good frame A/5/3, parity 0, held until consumed.
        send_body(4'hA, 4'h5, 4'h3, 1'b0);
        chk("good_c14_valid", out_valid, 0);
        send_stop(1'b0);
        chk("good_valid", out_valid, 1);
        chk("good_a", A_e, 4'hA);
        chk("good_b", B_e, 4'h5);
        chk("good_c", C_e, 4'h3);
        chk("good_fcnt", frame_cnt, 1);
        chk("good_perr", parity_err, 0);
        idle(5);
        chk("hold_valid", out_valid, 1);
        chk("hold_abc", {A_e, B_e, C_e}, 12'hA53);
        out_ready = 1'b1;
        send_bit(1'b0);
        out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);
        idle(2);

        // Parity error.
        send_body(4'hA, 4'h5, 4'h3, 1'b1);
        send_stop(1'b0);
        chk("perr_pulse", parity_err, 1);
        chk("perr_ferr", frame_err, 0);
        chk("perr_valid", out_valid, 0);
        chk("perr_ecnt", err_cnt, 1);
        send_bit(1'b0);
        chk("perr_pulse_end", parity_err, 0);
        idle(2);

        // Frame error with bad parity too: only frame_err, stop bit not a start.
        send_body(4'hA, 4'h5, 4'h3, 1'b1);
        send_stop(1'b1);
        chk("ferr_pulse", frame_err, 1);
        chk("ferr_perr", parity_err, 0);
        chk("ferr_ecnt", err_cnt, 2);
        chk("ferr_idle", dut.state_q, StIdle);
        idle(20);
        chk("ferr_no_frame", out_valid, 0);
        chk("ferr_fcnt", frame_cnt, 1);
        chk("ferr_ecnt_hold", err_cnt, 2);

        // Overrun: two back-to-back good frames, nobody ready.
        send_body(4'hF, 4'h0, 4'h1, 1'b0);
        send_stop(1'b0);
        chk("ovr1_valid", out_valid, 1);
        chk("ovr1_abc", {A_e, B_e, C_e}, 12'hF01);
        chk("ovr1_fcnt", frame_cnt, 2);
        chk("ovr1_ovr", overrun, 0);
        send_body(4'h2, 4'h4, 4'h8, 1'b0);
        send_stop(1'b0);
        chk("ovr2_abc", {A_e, B_e, C_e}, 12'hF01);
        chk("ovr2_ovr", overrun, 1);
        chk("ovr2_fcnt", frame_cnt, 2);
        chk("ovr2_valid", out_valid, 1);
        out_ready = 1'b1;
        send_bit(1'b0);
        out_ready = 1'b0;
        chk("ovr_drain", out_valid, 0);
        idle(2);

        // Same pair, consumer ready in the cycle the second frame lands.
        send_body(4'hF, 4'h0, 4'h1, 1'b0);
        send_stop(1'b0);
        chk("rdy1_fcnt", frame_cnt, 3);
        send_body(4'h2, 4'h4, 4'h8, 1'b0);
        out_ready = 1'b1;
        send_stop(1'b0);
        out_ready = 1'b0;
        chk("rdy2_valid", out_valid, 1);
        chk("rdy2_abc", {A_e, B_e, C_e}, 12'h248);
        chk("rdy2_fcnt", frame_cnt, 4);
        chk("rdy2_ovr", overrun, 1);
        idle(2);

        // Reset during cycle 7 of a frame, then a clean frame.
        send_bit(1'b1);
        for (int i = 0; i < 6; i++) send_bit(i[0]);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_abc", {A_e, B_e, C_e}, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_fcnt", frame_cnt, 0);
        chk("mid_rst_ecnt", err_cnt, 0);
        chk("mid_rst_pulses", {parity_err, frame_err}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(16);
        chk("post_rst_quiet", {out_valid, parity_err, frame_err, err_cnt}, 0);
        send_body(4'hA, 4'h5, 4'h3, 1'b0);
        send_stop(1'b0);
        chk("clean_valid", out_valid, 1);
        chk("clean_abc", {A_e, B_e, C_e}, 12'hA53);
        chk("clean_fcnt", frame_cnt, 1);
        chk("clean_pulses", {parity_err, frame_err}, 0);

        // Error counter saturation across 260 frame errors.
        for (int i = 0; i < 260; i++) begin
            send_body(4'h0, 4'h0, 4'h0, 1'b0);
            send_stop(1'b1);
            if (i == 253) chk("sat_254", err_cnt, 254);
            if (i == 254) chk("sat_255", err_cnt, 255);
        end
        chk("sat_260", err_cnt, 255);
        chk("sat_fcnt", frame_cnt, 1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
